// File: rtl/catch_round_arbiter.sv
// One round of the 2-player catch game: arm delay, timed catch window, winner pick, result hold.
// Optional macro CATCH_RR_TIE_EN: same-cycle ties alternate between A and B instead of always going to A.
module catch_round_arbiter #(
    parameter int ARM_CYCLES    = 25_000_000,
    parameter int WINDOW_CYCLES = 50_000_000,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int SCORE_W       = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Shot_A,
    input  logic               Shot_B,
    input  logic               Clear_Score,
    output logic               Busy,
    output logic               Window_Open,
    output logic               Win_A,
    output logic               Win_B,
    output logic               Miss,
    output logic               Foul_A,
    output logic               Foul_B,
    output logic [SCORE_W-1:0] Score_A,
    output logic [SCORE_W-1:0] Score_B
);

    localparam int CNT_MAX_01 = (ARM_CYCLES > WINDOW_CYCLES) ? ARM_CYCLES : WINDOW_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_01 > HOLD_CYCLES) ? CNT_MAX_01 : HOLD_CYCLES;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Counter loads are one less than the phase length because the load cycle counts.
    localparam logic [CNT_W-1:0]   ARM_LOAD  = CNT_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WIN_LOAD  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        OPEN   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               window_open_q, window_open_d;
    logic               win_a_q, win_a_d;
    logic               win_b_q, win_b_d;
    logic               miss_q, miss_d;
    logic               foul_a_q, foul_a_d;
    logic               foul_b_q, foul_b_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d;
    logic [SCORE_W-1:0] score_b_q, score_b_d;
    logic               award_a, award_b;
    logic               eligible_a, eligible_b;
`ifdef CATCH_RR_TIE_EN
    logic               prio_b_q, prio_b_d;
`endif

    assign eligible_a = Shot_A & ~foul_a_q;
    assign eligible_b = Shot_B & ~foul_b_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_a_d  = win_a_q;
        win_b_d  = win_b_q;
        miss_d   = miss_q;
        foul_a_d = foul_a_q;
        foul_b_d = foul_b_q;
        award_a  = 1'b0;
        award_b  = 1'b0;
`ifdef CATCH_RR_TIE_EN
        prio_b_d = prio_b_q;
`endif

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d  = ARM;
                    cnt_d    = ARM_LOAD;
                    foul_a_d = 1'b0;
                    foul_b_d = 1'b0;
                end
            end
            ARM: begin
                foul_a_d = foul_a_q | Shot_A;
                foul_b_d = foul_b_q | Shot_B;
                if (cnt_q == '0) begin
                    // A press on the last arm cycle still counts towards the double-foul skip.
                    if (foul_a_d && foul_b_d) begin
                        state_d = RESULT;
                        cnt_d   = HOLD_LOAD;
                        miss_d  = 1'b1;
                    end else begin
                        state_d = OPEN;
                        cnt_d   = WIN_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            OPEN: begin
                if (eligible_a && eligible_b) begin
`ifdef CATCH_RR_TIE_EN
                    award_a  = ~prio_b_q;
                    award_b  = prio_b_q;
                    prio_b_d = ~prio_b_q;
`else
                    award_a  = 1'b1;
`endif
                end else begin
                    award_a = eligible_a;
                    award_b = eligible_b;
                end

                if (award_a || award_b) begin
                    state_d = RESULT;
                    cnt_d   = HOLD_LOAD;
                    win_a_d = award_a;
                    win_b_d = award_b;
                end else if (cnt_q == '0) begin
                    state_d = RESULT;
                    cnt_d   = HOLD_LOAD;
                    miss_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESULT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    win_a_d = 1'b0;
                    win_b_d = 1'b0;
                    miss_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d        = (state_d != IDLE);
        window_open_d = (state_d == OPEN);

        // Clear takes precedence over a win landing in the same cycle.
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        if (Clear_Score) begin
            score_a_d = '0;
            score_b_d = '0;
        end else begin
            if (award_a && (score_a_q != SCORE_MAX)) score_a_d = score_a_q + SCORE_ONE;
            if (award_b && (score_b_q != SCORE_MAX)) score_b_d = score_b_q + SCORE_ONE;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            window_open_q <= 1'b0;
            win_a_q       <= 1'b0;
            win_b_q       <= 1'b0;
            miss_q        <= 1'b0;
            foul_a_q      <= 1'b0;
            foul_b_q      <= 1'b0;
            score_a_q     <= '0;
            score_b_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            window_open_q <= window_open_d;
            win_a_q       <= win_a_d;
            win_b_q       <= win_b_d;
            miss_q        <= miss_d;
            foul_a_q      <= foul_a_d;
            foul_b_q      <= foul_b_d;
            score_a_q     <= score_a_d;
            score_b_q     <= score_b_d;
        end
    end

`ifdef CATCH_RR_TIE_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) prio_b_q <= 1'b0;
        else       prio_b_q <= prio_b_d;
    end
`endif

    assign Busy        = busy_q;
    assign Window_Open = window_open_q;
    assign Win_A       = win_a_q;
    assign Win_B       = win_b_q;
    assign Miss        = miss_q;
    assign Foul_A      = foul_a_q;
    assign Foul_B      = foul_b_q;
    assign Score_A     = score_a_q;
    assign Score_B     = score_b_q;

endmodule

// File: tb/tb_catch_round_arbiter.sv
// Directed bench for catch_round_arbiter with short phase lengths and a 3-bit score.
module tb_catch_round_arbiter;

    localparam int ARM_C  = 4;
    localparam int WIN_C  = 8;
    localparam int HOLD_C = 3;
    localparam int SW     = 3;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Start, Shot_A, Shot_B, Clear_Score;
    logic          Busy, Window_Open, Win_A, Win_B, Miss, Foul_A, Foul_B;
    logic [SW-1:0] Score_A, Score_B;

    int checks = 0;
    int passed = 0;
    int expA   = 0;
    int expB   = 0;
    int n;

    catch_round_arbiter #(
        .ARM_CYCLES   (ARM_C),
        .WINDOW_CYCLES(WIN_C),
        .HOLD_CYCLES  (HOLD_C),
        .SCORE_W      (SW)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Shot_A     (Shot_A),
        .Shot_B     (Shot_B),
        .Clear_Score(Clear_Score),
        .Busy       (Busy),
        .Window_Open(Window_Open),
        .Win_A      (Win_A),
        .Win_B      (Win_B),
        .Miss       (Miss),
        .Foul_A     (Foul_A),
        .Foul_B     (Foul_B),
        .Score_A    (Score_A),
        .Score_B    (Score_B)
    );

    always #5 Clock = ~Clock;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One clock with the given inputs held, then all inputs back to 0.
    task automatic applyStimulus(input logic st, input logic sa, input logic sb, input logic cl);
        Start       = st;
        Shot_A      = sa;
        Shot_B      = sb;
        Clear_Score = cl;
        tick();
        Start       = 1'b0;
        Shot_A      = 1'b0;
        Shot_B      = 1'b0;
        Clear_Score = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return Window_Open;
            1:       return Win_A;
            2:       return Win_B;
            default: return Miss;
        endcase
    endfunction

    task automatic waitWindow(output int cyc);
        cyc = 0;
        while (Window_Open !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput("window_reached", 32'(Window_Open), 1);
    endtask

    task automatic waitIdle();
        int c = 0;
        while (Busy !== 1'b0 && c < 40) begin
            tick();
            c++;
        end
        checkOutput("idle_reached", 32'(Busy), 0);
    endtask

    task automatic countHigh(input int sel, output int cyc);
        cyc = 0;
        while (pick(sel) === 1'b1 && cyc < 40) begin
            cyc++;
            tick();
        end
    endtask

    initial begin
        Reset       = 1'b1;
        Start       = 1'b0;
        Shot_A      = 1'b0;
        Shot_B      = 1'b0;
        Clear_Score = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy", 32'(Busy), 0);
        checkOutput("rst_window", 32'(Window_Open), 0);
        checkOutput("rst_wins", {30'd0, Win_A, Win_B}, 0);
        checkOutput("rst_miss_fouls", {29'd0, Miss, Foul_A, Foul_B}, 0);
        checkOutput("rst_scores", {26'd0, Score_A, Score_B}, 0);
        Reset = 1'b0;
        tick();

        // Round 1: B catches on the second open cycle.
        applyStimulus(1, 0, 0, 0);
        checkOutput("r1_busy", 32'(Busy), 1);
        waitWindow(n);
        checkOutput("r1_arm_len", n, ARM_C);
        tick();
        applyStimulus(0, 0, 1, 0);
        expB = 1;
        checkOutput("r1_win_b", 32'(Win_B), 1);
        checkOutput("r1_win_a", 32'(Win_A), 0);
        checkOutput("r1_window_closed", 32'(Window_Open), 0);
        checkOutput("r1_score_b", 32'(Score_B), expB);
        checkOutput("r1_score_a", 32'(Score_A), expA);
        countHigh(2, n);
        checkOutput("r1_hold_len", n, HOLD_C);
        checkOutput("r1_idle", 32'(Busy), 0);

        // Round 2: nobody presses.
        applyStimulus(1, 0, 0, 0);
        waitWindow(n);
        countHigh(0, n);
        checkOutput("r2_window_len", n, WIN_C);
        checkOutput("r2_miss", 32'(Miss), 1);
        checkOutput("r2_no_win", {30'd0, Win_A, Win_B}, 0);
        countHigh(3, n);
        checkOutput("r2_miss_len", n, HOLD_C);
        checkOutput("r2_score_a", 32'(Score_A), expA);
        checkOutput("r2_score_b", 32'(Score_B), expB);
        checkOutput("r2_idle", 32'(Busy), 0);

        // Round 3: A fouls during arm, then both press together; only B is eligible.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("r3_foul_a", 32'(Foul_A), 1);
        checkOutput("r3_foul_b", 32'(Foul_B), 0);
        waitWindow(n);
        applyStimulus(0, 1, 1, 0);
        expB = 2;
        checkOutput("r3_win_b", 32'(Win_B), 1);
        checkOutput("r3_win_a", 32'(Win_A), 0);
        checkOutput("r3_score_b", 32'(Score_B), expB);
        waitIdle();
        checkOutput("r3_foul_held", 32'(Foul_A), 1);

        // Rounds 4-5: clean ties.
        applyStimulus(1, 0, 0, 0);
        checkOutput("r4_foul_cleared", 32'(Foul_A), 0);
        waitWindow(n);
        applyStimulus(0, 1, 1, 0);
        expA = 1;
        checkOutput("r4_tie_win_a", 32'(Win_A), 1);
        checkOutput("r4_tie_score_a", 32'(Score_A), expA);
        waitIdle();
        applyStimulus(1, 0, 0, 0);
        waitWindow(n);
        applyStimulus(0, 1, 1, 0);
`ifdef CATCH_RR_TIE_EN
        expB = 3;
        checkOutput("r5_tie_win_b", 32'(Win_B), 1);
`else
        expA = 2;
        checkOutput("r5_tie_win_a", 32'(Win_A), 1);
`endif
        checkOutput("r5_score_a", 32'(Score_A), expA);
        checkOutput("r5_score_b", 32'(Score_B), expB);
        waitIdle();

        // Nine A wins saturate the 3-bit score at 7.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 0, 0, 0);
            waitWindow(n);
            applyStimulus(0, 1, 0, 0);
            expA = (expA < 7) ? expA + 1 : 7;
            waitIdle();
        end
        checkOutput("sat_score_a", 32'(Score_A), 7);
        checkOutput("sat_score_b", 32'(Score_B), expB);

        // Clear lands on the same edge as an A win.
        applyStimulus(1, 0, 0, 0);
        waitWindow(n);
        applyStimulus(0, 1, 0, 1);
        expA = 0;
        expB = 0;
        checkOutput("clr_win_a", 32'(Win_A), 1);
        checkOutput("clr_score_a", 32'(Score_A), expA);
        checkOutput("clr_score_b", 32'(Score_B), expB);
        waitIdle();

        // Start during RESULT must not launch another round.
        applyStimulus(1, 0, 0, 0);
        waitWindow(n);
        applyStimulus(0, 1, 0, 0);
        expA = 1;
        checkOutput("res_score_a", 32'(Score_A), expA);
        applyStimulus(1, 0, 0, 0);
        checkOutput("res_still_win", 32'(Win_A), 1);
        waitIdle();
        tick();
        tick();
        checkOutput("res_start_ignored", 32'(Busy), 0);
        checkOutput("res_no_window", 32'(Window_Open), 0);

        // Reset in the middle of the open window.
        applyStimulus(1, 0, 0, 0);
        waitWindow(n);
        tick();
        Reset = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 32'(Busy), 0);
        checkOutput("mid_rst_window", 32'(Window_Open), 0);
        checkOutput("mid_rst_scores", {26'd0, Score_A, Score_B}, 0);
        tick();
        Reset = 1'b0;
        tick();
        checkOutput("post_rst_idle", 32'(Busy), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
